// File: rtl/apple_locator.sv
// -----------------------------------------------------------------------------
// apple_locator
// Picks a free grid cell for the next apple. A free-running 16-bit LFSR
// proposes candidate cells. Each in-range candidate is compared against the
// snake body one segment per clock. The first candidate that is clear of the
// body is published on randX/randY, together with a one-cycle rand_valid
// strobe.
//
// Configuration macro: APPLE_LOCATOR_STATS_EN
//   When defined, the block adds the output last_tries[7:0]. It holds the
//   rejection count of the most recent search.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   s_reset    in   synchronous soft reset (game restart), active-high;
//                   does not reseed the LFSR
//   req        in   request a new apple cell (sampled in IDLE only)
//   body       in   snake segments, {x[7:4], y[3:0]}, body[0] = head
//   snake_len  in   number of valid segments (clamped to MAX_LEN)
//   randX/Y    out  published apple cell
//   rand_valid out  one-cycle strobe: randX/randY/fail updated this cycle
//   busy       out  search in progress (DRAW/SCAN/DONE)
//   fail       out  last search hit MAX_TRIES rejections (sticky)
//   last_tries out  (stats build only) rejection count of the last search
// -----------------------------------------------------------------------------
module apple_locator #(
  parameter int unsigned GRID_W    = 14,
  parameter int unsigned GRID_H    = 14,
  parameter int unsigned MAX_LEN   = 50,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned INIT_X    = 5,
  parameter int unsigned INIT_Y    = 8,
  parameter int unsigned MAX_TRIES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_reset,
  input  logic                     req,
  input  logic [MAX_LEN-1:0][7:0]  body,
  input  logic [5:0]               snake_len,
  output logic [3:0]               randX,
  output logic [3:0]               randY,
  output logic                     rand_valid,
  output logic                     busy,
  output logic                     fail
`ifdef APPLE_LOCATOR_STATS_EN
  ,
  output logic [7:0]               last_tries
`endif
);

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned TRY_W  = 8;
  localparam int unsigned CRD_W  = 4;
  localparam int unsigned CELL_W = 8;

  localparam logic [CRD_W-1:0] RST_X   = CRD_W'(INIT_X);
  localparam logic [CRD_W-1:0] RST_Y   = CRD_W'(INIT_Y);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [LFSR_W-1:0]   w_lfsr_nxt;
  logic [TRY_W-1:0]    r_tries;
  logic [TRY_W-1:0]    w_tries_nxt;
  logic [TRY_W-1:0]    w_tries_inc;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [CELL_W-1:0]   r_cand;
  logic [CELL_W-1:0]   w_cand_nxt;
  logic [CRD_W-1:0]    w_x_nxt;
  logic [CRD_W-1:0]    w_y_nxt;
  logic                w_valid_nxt;
  logic                w_busy_nxt;
  logic                w_fail_nxt;

  logic [CRD_W-1:0]    w_cx;
  logic [CRD_W-1:0]    w_cy;
  logic                w_in_range;
  logic [LEN_W-1:0]    w_len;
  logic                w_last;
  logic                w_give_up;
  logic [CELL_W-1:0]   w_seg;
  logic                w_hit;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left
  assign w_lfsr_nxt = {r_lfsr[LFSR_W-2:0],
                       r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  // The LFSR advances every cycle; only the hard reset reseeds it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_lfsr <= SEED;
    else        r_lfsr <= w_lfsr_nxt;
  end

  // Candidate cell straight from the LFSR low byte
  assign w_cx       = r_lfsr[7:4];
  assign w_cy       = r_lfsr[3:0];
  assign w_in_range = (32'(w_cx) < GRID_W) && (32'(w_cy) < GRID_H);

  // Effective body length, clamped to the array depth
  assign w_len  = (snake_len > LEN_MAX) ? LEN_MAX : snake_len;
  assign w_last = (r_idx == IDX_W'(w_len - LEN_W'(1)));

  // Saturating rejection counter and give-up test on the post-increment value
  assign w_tries_inc = (r_tries == '1) ? r_tries : r_tries + TRY_W'(1);
  assign w_give_up   = (w_tries_inc >= TRY_MAX);

  // Segment selected by the scan index; out-of-range index reads as zero
  always_comb begin
    w_seg = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (r_idx == IDX_W'(i)) w_seg = body[i];
    end
  end

  assign w_hit = (w_seg == r_cand);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_tries_nxt = r_tries;
    w_idx_nxt   = r_idx;
    w_cand_nxt  = r_cand;
    w_x_nxt     = randX;
    w_y_nxt     = randY;
    w_fail_nxt  = fail;

    unique case (r_state)
      S_IDLE: begin
        if (req) begin
          w_state_nxt = S_DRAW;
          w_tries_nxt = '0;
          w_fail_nxt  = 1'b0;
        end
      end

      S_DRAW: begin
        if (!w_in_range) begin
          w_tries_nxt = w_tries_inc;
          if (w_give_up) begin
            w_state_nxt = S_DONE;
            w_fail_nxt  = 1'b1;
          end
        end else begin
          w_cand_nxt = {w_cx, w_cy};
          w_idx_nxt  = '0;
          if (w_len == '0) begin
            // Empty body: every in-range cell is free
            w_state_nxt = S_DONE;
            w_x_nxt     = w_cx;
            w_y_nxt     = w_cy;
          end else begin
            w_state_nxt = S_SCAN;
          end
        end
      end

      S_SCAN: begin
        if (w_hit) begin
          w_tries_nxt = w_tries_inc;
          if (w_give_up) begin
            w_state_nxt = S_DONE;
            w_fail_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_DRAW;
          end
        end else if (w_last) begin
          w_state_nxt = S_DONE;
          w_x_nxt     = r_cand[7:4];
          w_y_nxt     = r_cand[3:0];
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Soft restart overrides everything except the LFSR
    if (s_reset) begin
      w_state_nxt = S_IDLE;
      w_tries_nxt = '0;
      w_idx_nxt   = '0;
      w_cand_nxt  = '0;
      w_x_nxt     = RST_X;
      w_y_nxt     = RST_Y;
      w_fail_nxt  = 1'b0;
    end

    // Status outputs follow the state being entered so they align with it
    w_valid_nxt = (w_state_nxt == S_DONE);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_tries    <= '0;
      r_idx      <= '0;
      r_cand     <= '0;
      randX      <= RST_X;
      randY      <= RST_Y;
      rand_valid <= 1'b0;
      busy       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tries    <= w_tries_nxt;
      r_idx      <= w_idx_nxt;
      r_cand     <= w_cand_nxt;
      randX      <= w_x_nxt;
      randY      <= w_y_nxt;
      rand_valid <= w_valid_nxt;
      busy       <= w_busy_nxt;
      fail       <= w_fail_nxt;
    end
  end

`ifdef APPLE_LOCATOR_STATS_EN
  // Final rejection count, captured as the search completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_tries <= '0;
    end else if (s_reset) begin
      last_tries <= '0;
    end else if (w_state_nxt == S_DONE) begin
      last_tries <= w_tries_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_apple_locator.sv
// Scoreboard bench for apple_locator. Three instances: the default 14x14
// grid, a 2x2 grid with three cells occupied, and a 2x2 grid that is fully
// occupied with MAX_TRIES=4. Expected cells, fail flags, rejection counts and
// strobe cycles come from a reference search model driven by the bench's own
// LFSR.
`timescale 1ns/1ps
module tb_apple_locator;

  localparam int ML = 50;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       f;
    logic [7:0] tries;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             a_sr, a_req, a_v, a_busy, a_fail;
  logic [ML-1:0][7:0] a_body;
  logic [5:0]       a_len;
  logic [3:0]       a_x, a_y;
  logic             b_sr, b_req, b_v, b_busy, b_fail;
  logic [ML-1:0][7:0] b_body;
  logic [5:0]       b_len;
  logic [3:0]       b_x, b_y;
  logic             c_sr, c_req, c_v, c_busy, c_fail;
  logic [ML-1:0][7:0] c_body;
  logic [5:0]       c_len;
  logic [3:0]       c_x, c_y;
`ifdef APPLE_LOCATOR_STATS_EN
  logic [7:0]       a_lt, b_lt, c_lt;
`endif

  apple_locator u_a (
    .clk(clk), .reset(rst_n), .s_reset(a_sr), .req(a_req), .body(a_body),
    .snake_len(a_len), .randX(a_x), .randY(a_y), .rand_valid(a_v),
    .busy(a_busy), .fail(a_fail)
`ifdef APPLE_LOCATOR_STATS_EN
    , .last_tries(a_lt)
`endif
  );

  apple_locator #(.GRID_W(2), .GRID_H(2)) u_b (
    .clk(clk), .reset(rst_n), .s_reset(b_sr), .req(b_req), .body(b_body),
    .snake_len(b_len), .randX(b_x), .randY(b_y), .rand_valid(b_v),
    .busy(b_busy), .fail(b_fail)
`ifdef APPLE_LOCATOR_STATS_EN
    , .last_tries(b_lt)
`endif
  );

  apple_locator #(.GRID_W(2), .GRID_H(2), .MAX_TRIES(4)) u_c (
    .clk(clk), .reset(rst_n), .s_reset(c_sr), .req(c_req), .body(c_body),
    .snake_len(c_len), .randX(c_x), .randY(c_y), .rand_valid(c_v),
    .busy(c_busy), .fail(c_fail)
`ifdef APPLE_LOCATOR_STATS_EN
    , .last_tries(c_lt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [15:0] m_lfsr;
  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  logic [3:0] px[3];
  logic [3:0] py[3];

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference LFSR: seeded by the hard reset only
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= step(m_lfsr);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string tag);
    n_cmp++;
    n_bad++;
    $display("FAIL %s_unexpected_valid: rand_valid=1 at cycle %0d, required no strobe", tag, cyc);
  endtask

  // Search model: l0 is the LFSR value during the first DRAW cycle, c0 the
  // edge count at which DRAW was entered
  function automatic exp_t model(input logic [15:0] l0, input int gw, input int gh,
                                 input int mt, input logic [ML-1:0][7:0] bd,
                                 input logic [5:0] len_in, input logic [3:0] prx,
                                 input logic [3:0] pry, input int c0);
    exp_t e;
    logic [15:0] l;
    logic [7:0] cand;
    int tries, n, len, cx, cy;
    bit done, hit;
    l = l0; tries = 0; n = 0; done = 0;
    len = (32'(len_in) > ML) ? ML : 32'(len_in);
    e.x = prx; e.y = pry; e.f = 1'b0;
    while (!done) begin
      cand = l[7:0];
      cx = 32'(l[7:4]);
      cy = 32'(l[3:0]);
      l = step(l); n++;
      if (cx >= gw || cy >= gh) begin
        tries++;
        if (tries >= mt) begin e.f = 1'b1; done = 1; end
      end else if (len == 0) begin
        e.x = cand[7:4]; e.y = cand[3:0]; done = 1;
      end else begin
        hit = 0;
        for (int k = 0; k < len && !hit; k++) begin
          l = step(l); n++;
          if (bd[k] == cand) hit = 1;
        end
        if (hit) begin
          tries++;
          if (tries >= mt) begin e.f = 1'b1; done = 1; end
        end else begin
          e.x = cand[7:4]; e.y = cand[3:0]; done = 1;
        end
      end
    end
    e.tries = 8'(tries);
    e.cyc = c0 + n;
    return e;
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0: return a_busy;
      1: return b_busy;
      default: return c_busy;
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0: return qa.size();
      1: return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic set_req(input int d, input logic v);
    case (d)
      0: a_req = v;
      1: b_req = v;
      default: c_req = v;
    endcase
  endtask

  task automatic reset_prev();
    for (int i = 0; i < 3; i++) begin
      px[i] = 4'd5;
      py[i] = 4'd8;
    end
  endtask

  // One-cycle request; optionally pushes the model's expected response
  task automatic issue(input int d, input bit push);
    exp_t e;
    logic [15:0] l0;
    int c0;
    @(negedge clk);
    set_req(d, 1'b1);
    @(posedge clk);
    #1;
    set_req(d, 1'b0);
    l0 = m_lfsr;
    c0 = cyc;
    chk("busy_after_req", 32'(get_busy(d)), 1);
    if (push) begin
      case (d)
        0: e = model(l0, 14, 14, 255, a_body, a_len, px[0], py[0], c0);
        1: e = model(l0, 2, 2, 255, b_body, b_len, px[1], py[1], c0);
        default: e = model(l0, 2, 2, 4, c_body, c_len, px[2], py[2], c0);
      endcase
      if (!e.f) begin
        px[d] = e.x;
        py[d] = e.y;
      end
      case (d)
        0: qa.push_back(e);
        1: qb.push_back(e);
        default: qc.push_back(e);
      endcase
    end
  endtask

  task automatic drain(input int d, input int budget);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", 32'(qsize(d) == 0), 1);
  endtask

  task automatic check_exp(input string tag, input exp_t e, input logic [3:0] x,
                           input logic [3:0] y, input logic f);
    chk({tag, "_randX"}, 32'(x), 32'(e.x));
    chk({tag, "_randY"}, 32'(y), 32'(e.y));
    chk({tag, "_fail"}, 32'(f), 32'(e.f));
    chk({tag, "_valid_cycle"}, 32'(cyc), 32'(e.cyc));
  endtask

  // Monitors: pop and compare on every strobe
  always @(negedge clk) begin
    if (a_v === 1'b1) begin
      if (qa.size() == 0) unexpected("a");
      else begin
        ea = qa.pop_front();
        check_exp("a", ea, a_x, a_y, a_fail);
`ifdef APPLE_LOCATOR_STATS_EN
        chk("a_last_tries", 32'(a_lt), 32'(ea.tries));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (b_v === 1'b1) begin
      if (qb.size() == 0) unexpected("b");
      else begin
        eb = qb.pop_front();
        check_exp("b", eb, b_x, b_y, b_fail);
        if (!eb.f) begin
          // Only cell (1,1) is free on this board
          chk("b_free_x", 32'(b_x), 1);
          chk("b_free_y", 32'(b_y), 1);
        end
`ifdef APPLE_LOCATOR_STATS_EN
        chk("b_last_tries", 32'(b_lt), 32'(eb.tries));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (c_v === 1'b1) begin
      if (qc.size() == 0) unexpected("c");
      else begin
        ec = qc.pop_front();
        check_exp("c", ec, c_x, c_y, c_fail);
        chk("c_giveup_fail", 32'(c_fail), 1);
        chk("c_hold_x", 32'(c_x), 5);
        chk("c_hold_y", 32'(c_y), 8);
`ifdef APPLE_LOCATOR_STATS_EN
        chk("c_last_tries", 32'(c_lt), 32'(ec.tries));
`endif
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_a_reset(input string tag);
    chk({tag, "_randX"}, 32'(a_x), 5);
    chk({tag, "_randY"}, 32'(a_y), 8);
    chk({tag, "_valid"}, 32'(a_v), 0);
    chk({tag, "_busy"}, 32'(a_busy), 0);
    chk({tag, "_fail"}, 32'(a_fail), 0);
`ifdef APPLE_LOCATOR_STATS_EN
    chk({tag, "_last_tries"}, 32'(a_lt), 0);
`endif
  endtask

  initial begin
    a_sr = 0; a_req = 0; a_len = '0; a_body = '0;
    b_sr = 0; b_req = 0; b_len = '0; b_body = '0;
    c_sr = 0; c_req = 0; c_len = '0; c_body = '0;
    for (int i = 0; i < ML; i++) a_body[i] = {4'(i % 14), 4'(i / 14)};
    b_body[0] = 8'h00; b_body[1] = 8'h01; b_body[2] = 8'h10;
    c_body[0] = 8'h00; c_body[1] = 8'h01; c_body[2] = 8'h10; c_body[3] = 8'h11;
    reset_prev();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check_a_reset("por");
    chk("por_c_valid", 32'(c_v), 0);

    // Empty body: first in-range candidate wins
    a_len = 6'd0;
    issue(0, 1'b1);
    drain(0, 1000);

    // Mid-cycle async reset takes effect before the next edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_a_reset("async_idle");
    @(negedge clk);
    rst_n = 1'b1;
    reset_prev();

    // 2x2 board with one free cell
    b_len = 6'd3;
    for (int r = 0; r < 100; r++) begin
      issue(1, 1'b1);
      drain(1, 1500);
    end

    // Fully occupied 2x2 board gives up after four rejections
    c_len = 6'd4;
    issue(2, 1'b1);
    drain(2, 400);
    chk("c_fail_sticky", 32'(c_fail), 1);

    // A request while busy is ignored
    a_len = 6'd50;
    issue(0, 1'b1);
    repeat (4) @(negedge clk);
    a_req = 1'b1;
    @(negedge clk);
    a_req = 1'b0;
    drain(0, 15000);
    repeat (80) @(negedge clk);

    // Soft reset mid-search aborts with no strobe
    issue(0, 1'b0);
    repeat (5) @(negedge clk);
    a_sr = 1'b1;
    @(posedge clk);
    #1;
    check_a_reset("s_reset");
    @(negedge clk);
    a_sr = 1'b0;
    px[0] = 4'd5;
    py[0] = 4'd8;
    repeat (80) @(negedge clk);

    // Hard reset mid-search, then a clamped-length search completes
    issue(0, 1'b0);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_a_reset("async_scan");
    @(negedge clk);
    rst_n = 1'b1;
    reset_prev();
    a_len = 6'd63;
    issue(0, 1'b1);
    drain(0, 15000);
    repeat (5) @(negedge clk);

    chk("qa_empty", 32'(qa.size()), 0);
    chk("qb_empty", 32'(qb.size()), 0);
    chk("qc_empty", 32'(qc.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
